// File: rtl/reaction_timer.sv
// reaction_timer: game controller for the FPGA reaction game.
// Synchronises and edge-detects the buttons, runs the IDLE/ARM/GO/RESULT game
// FSM with an LFSR-randomised wait and a millisecond prescaler, and drives the
// seven-segment display inputs (number/select/mode) plus the GO LED.
// Optional feature: define REACTION_BEST_EN to add best-time tracking
// (outputs best and new_best).
module reaction_timer #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned MIN_DELAY = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_react,
    input  logic        btn_mode,
    output logic [13:0] number,
    output logic [1:0]  select,
    output logic [1:0]  mode,
`ifdef REACTION_BEST_EN
    output logic        go_led,
    output logic [13:0] best,
    output logic        new_best
`else
    output logic        go_led
`endif
);

    localparam int unsigned CntW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [13:0] MaxNumber = 14'd9999;

    typedef enum logic [1:0] {StIdle, StArm, StGo, StResult} state_e;

    // Button pipeline, bit order {mode, react, start}
    logic [2:0] sync1_q, sync2_q, prev_q;
    logic [2:0] btn_rise;
    logic       start_rise, react_rise, mode_rise;

    logic [15:0]     lfsr_q;
    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    logic            tick, tick_clr;

    state_e      state_q, state_d;
    logic [13:0] number_q, number_d;
    logic [1:0]  select_q, select_d;
    logic [1:0]  mode_q, mode_d;
    logic        go_led_q, go_led_d;
    logic [11:0] delay_q, delay_d;
    logic [13:0] limit;
`ifdef REACTION_BEST_EN
    logic [13:0] best_q, best_d;
    logic        new_best_q, new_best_d;
`endif

    // Two-flop synchroniser plus previous-value flop per button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
        end else begin
            sync1_q <= {btn_mode, btn_react, btn_start};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign btn_rise   = sync2_q & ~prev_q;
    assign start_rise = btn_rise[0];
    assign react_rise = btn_rise[1];
    assign mode_rise  = btn_rise[2];

    // 16-bit Fibonacci LFSR, taps 16,14,13,11; free-running every clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign tick = (tick_cnt_q == CntW'(TICK_DIV - 1));

    // Millisecond prescaler; restarts on ARM/GO entry so phases are exact
    always_comb begin
        tick_cnt_d = tick_cnt_q + CntW'(1);
        if (tick_clr || tick) begin
            tick_cnt_d = '0;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Timeout limit for the current mode
    always_comb begin
        unique case (mode_q)
            2'd0:    limit = 14'd2000;
            2'd1:    limit = 14'd1000;
            default: limit = 14'd500;
        endcase
    end

    // Game FSM next-state and registered-output next values
    always_comb begin
        state_d  = state_q;
        number_d = number_q;
        select_d = select_q;
        mode_d   = mode_q;
        go_led_d = go_led_q;
        delay_d  = delay_q;
        tick_clr = 1'b0;
`ifdef REACTION_BEST_EN
        best_d     = best_q;
        new_best_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (mode_rise) begin
                    mode_d = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
                end
                if (start_rise) begin
                    delay_d  = 12'(MIN_DELAY) + {1'b0, lfsr_q[10:0]};
                    number_d = '0;
                    select_d = 2'd1;
                    state_d  = StArm;
                    tick_clr = 1'b1;
                end
            end
            StArm: begin
                // A react during the wait is a false start, even on the final tick
                if (react_rise) begin
                    number_d = MaxNumber;
                    select_d = 2'd2;
                    state_d  = StResult;
                end else if (tick) begin
                    delay_d = delay_q - 12'd1;
                    if (delay_q == 12'd1) begin
                        go_led_d = 1'b1;
                        state_d  = StGo;
                        tick_clr = 1'b1;
                    end
                end
            end
            StGo: begin
                // React beats a coincident tick: the count holds
                if (react_rise) begin
                    go_led_d = 1'b0;
                    select_d = 2'd2;
                    state_d  = StResult;
`ifdef REACTION_BEST_EN
                    if (number_q < best_q) begin
                        best_d     = number_q;
                        new_best_d = 1'b1;
                    end
`endif
                end else if (tick) begin
                    if (number_q + 14'd1 == limit) begin
                        number_d = MaxNumber;
                        go_led_d = 1'b0;
                        select_d = 2'd2;
                        state_d  = StResult;
                    end else begin
                        number_d = number_q + 14'd1;
                    end
                end
            end
            StResult: begin
                go_led_d = 1'b0;
                if (start_rise) begin
                    number_d = '0;
                    select_d = 2'd0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Game state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            number_q <= '0;
            select_q <= 2'd0;
            mode_q   <= 2'd0;
            go_led_q <= 1'b0;
            delay_q  <= '0;
        end else begin
            state_q  <= state_d;
            number_q <= number_d;
            select_q <= select_d;
            mode_q   <= mode_d;
            go_led_q <= go_led_d;
            delay_q  <= delay_d;
        end
    end

`ifdef REACTION_BEST_EN
    // Best reaction time and its one-cycle improvement pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_q     <= MaxNumber;
            new_best_q <= 1'b0;
        end else begin
            best_q     <= best_d;
            new_best_q <= new_best_d;
        end
    end

    assign best     = best_q;
    assign new_best = new_best_q;
`endif

    assign number = number_q;
    assign select = select_q;
    assign mode   = mode_q;
    assign go_led = go_led_q;

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed self-checking bench for reaction_timer (TICK_DIV=4).
module tb_reaction_timer;

    localparam int unsigned TickDiv  = 4;
    localparam int unsigned MinDelay = 100;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        btn_start = 1'b0;
    logic        btn_react = 1'b0;
    logic        btn_mode  = 1'b0;
    logic [13:0] number;
    logic [1:0]  select;
    logic [1:0]  mode;
    logic        go_led;
`ifdef REACTION_BEST_EN
    logic [13:0] best;
    logic        new_best;
`endif

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference LFSR and its value one clock earlier
    logic [15:0] lfsr_m, lfsr_prev;

    reaction_timer #(
        .TICK_DIV (TickDiv),
        .MIN_DELAY(MinDelay)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .btn_react(btn_react),
        .btn_mode (btn_mode),
        .number   (number),
        .select   (select),
        .mode     (mode),
`ifdef REACTION_BEST_EN
        .go_led   (go_led),
        .best     (best),
        .new_best (new_best)
`else
        .go_led   (go_led)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_m    <= 16'hACE1;
            lfsr_prev <= 16'hACE1;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // 0 = start, 1 = react, 2 = mode
    task automatic pulse_btn(input int b);
        case (b)
            0:       btn_start = 1'b1;
            1:       btn_react = 1'b1;
            default: btn_mode  = 1'b1;
        endcase
        repeat (5) @(negedge clk);
        btn_start = 1'b0;
        btn_react = 1'b0;
        btn_mode  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ack();
        pulse_btn(0);
        check("ack_select", 32'(select), 0);
        check("ack_number", 32'(number), 0);
    endtask

    // Press start and stop at the first negedge after ARM entry
    task automatic begin_arm(output int exp_cycles);
        int n;
        n = 0;
        btn_start = 1'b1;
        while (select !== 2'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        btn_start = 1'b0;
        exp_cycles = (int'(MinDelay) + int'(lfsr_prev[10:0])) * int'(TickDiv);
        check("arm_select", 32'(select), 1);
        check("arm_number", 32'(number), 0);
        check("arm_go_led", 32'(go_led), 0);
    endtask

    // Count cycles from ARM entry to go_led rising
    task automatic wait_go(input int exp_cycles);
        int n;
        n = 0;
        while (go_led !== 1'b1 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        check("arm_length", n, exp_cycles);
        check("go_number", 32'(number), 0);
    endtask

    task automatic wait_number(input int v);
        int n;
        n = 0;
        while (number !== 14'(v) && n < 12000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (select !== 2'd2 && cyc < 10000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

`ifdef REACTION_BEST_EN
    task automatic play_best(input int v, input int exp_best, input int exp_pulse);
        int e;
        begin_arm(e);
        wait_go(e);
        wait_number(v);
        btn_react = 1'b1;
        repeat (3) @(negedge clk);
        check("best_number", 32'(number), v);
        check("best_value", 32'(best), exp_best);
        check("best_pulse", 32'(new_best), exp_pulse);
        @(negedge clk);
        check("best_pulse_end", 32'(new_best), 0);
        btn_react = 1'b0;
        ack();
    endtask
`endif

    initial begin
        int e;
        int cyc;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_number", 32'(number), 0);
        check("rst_select", 32'(select), 0);
        check("rst_mode", 32'(mode), 0);
        check("rst_go_led", 32'(go_led), 0);
`ifdef REACTION_BEST_EN
        check("rst_best", 32'(best), 9999);
        check("rst_new_best", 32'(new_best), 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // Mode cycling in IDLE
        pulse_btn(2);
        check("mode_1", 32'(mode), 1);
        pulse_btn(2);
        check("mode_2", 32'(mode), 2);
        check("mode_select", 32'(select), 0);
        pulse_btn(2);
        check("mode_wrap", 32'(mode), 0);
        check("mode_select", 32'(select), 0);
        check("mode_number", 32'(number), 0);

        // Normal game, react after 37 ticks
        begin_arm(e);
        wait_go(e);
        wait_number(37);
        btn_react = 1'b1;
        repeat (4) @(negedge clk);
        btn_react = 1'b0;
        check("r37_select", 32'(select), 2);
        check("r37_number", 32'(number), 37);
        check("r37_go_led", 32'(go_led), 0);
        repeat (2) @(negedge clk);
        ack();

        // False start during ARM
        begin_arm(e);
        repeat (10) @(negedge clk);
        check("fs_go_led_arm", 32'(go_led), 0);
        pulse_btn(1);
        check("fs_select", 32'(select), 2);
        check("fs_number", 32'(number), 9999);
        check("fs_go_led", 32'(go_led), 0);
        repeat (20) @(negedge clk);
        check("fs_go_led_later", 32'(go_led), 0);
        ack();

        // React edge lands on the same cycle as the tick that would make 13
        begin_arm(e);
        wait_go(e);
        wait_number(12);
        @(negedge clk);
        btn_react = 1'b1;
        repeat (3) @(negedge clk);
        check("tie_select", 32'(select), 2);
        check("tie_number", 32'(number), 12);
        btn_react = 1'b0;
        repeat (8) @(negedge clk);
        check("tie_frozen", 32'(number), 12);
        check("tie_go_led", 32'(go_led), 0);
        ack();

        // Hard mode timeout
        pulse_btn(2);
        pulse_btn(2);
        check("hard_mode", 32'(mode), 2);
        begin_arm(e);
        wait_go(e);
        wait_result(cyc);
        check("hard_cycles", cyc, 500 * TickDiv);
        check("hard_number", 32'(number), 9999);
        check("hard_go_led", 32'(go_led), 0);
        ack();

        // Reset asserted mid-GO takes effect without waiting for a clock
        begin_arm(e);
        wait_go(e);
        repeat (20) @(negedge clk);
        check("mid_number", 32'(number), 5);
        rst = 1'b0;
        #1;
        check("arst_number", 32'(number), 0);
        check("arst_select", 32'(select), 0);
        check("arst_mode", 32'(mode), 0);
        check("arst_go_led", 32'(go_led), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Easy mode timeout
        begin_arm(e);
        wait_go(e);
        wait_result(cyc);
        check("easy_cycles", cyc, 2000 * TickDiv);
        check("easy_number", 32'(number), 9999);
        ack();

`ifdef REACTION_BEST_EN
        play_best(120, 120, 1);
        play_best(80, 80, 1);
        play_best(95, 80, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
